// File: rtl/hv_accum_stream.sv
// hv_accum_stream: multi-core hypervector bundling accumulator.
// Each dimension keeps a saturating signed vote counter fed by every storing
// core (+1 for a 1 bit, -1 for a 0 bit). The live majority sign vector is
// always available. On start it is snapshotted and streamed out as OUT_W-bit
// beats over a valid/ready interface, lowest dimensions first.
module hv_accum_stream #(
    parameter int   DIM          = 1024,
    parameter int   CORENUM      = 8,
    parameter int   W            = 26,
    parameter int   OUT_W        = 512,
    parameter logic TIE_VAL      = 1'b0,
    parameter bit   CLR_ON_START = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CORENUM*DIM-1:0] core_result,
    input  logic [CORENUM-1:0]     store,
    input  logic                   clear,
    input  logic                   start,
    output logic [OUT_W-1:0]       m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done,
    output logic [DIM-1:0]         sign_bit
);

    localparam int NBEATS = DIM / OUT_W;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    // One extra bit of headroom: |cnt| + CORENUM always fits before clamping.
    localparam int SW     = W + 1;

    localparam logic [BW-1:0]        LAST_BEAT = BW'(NBEATS - 1);
    localparam logic [BW-1:0]        BEAT_ONE  = BW'(1'b1);
    localparam logic signed [SW-1:0] P_ZERO    = {SW{1'b0}};
    localparam logic signed [SW-1:0] P_ONE     = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] N_ONE     = {SW{1'b1}};
    localparam logic signed [SW-1:0] P_MAX     = {2'b00, {(W-1){1'b1}}};
    // Symmetric clamp: the most-negative W-bit code is never produced.
    localparam logic signed [SW-1:0] N_MAX     = -P_MAX;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic signed [W-1:0] cnt_r [DIM];
    logic signed [W-1:0] cnt_s [DIM];
    logic                clr_s;

    state_t              state_r, state_s;
    logic [BW-1:0]       beat_r, beat_s;
    logic [DIM-1:0]      snap_r, snap_s;
    logic                m_valid_r, m_valid_s;
    logic                m_last_r, m_last_s;
    logic [OUT_W-1:0]    m_data_r, m_data_s;
    logic                busy_r;
    logic                done_r, done_s;

    // Next counter value per dimension: sum of votes, clamp, clear/start-clear priority
    always_comb begin
        logic signed [SW-1:0] sum_v;
        sum_v = P_ZERO;
        // A start accepted in IDLE zeroes the counters and drops that cycle's stores.
        clr_s = clear | (CLR_ON_START & start & (state_r == S_IDLE));
        for (int d = 0; d < DIM; d++) begin
            sum_v = {cnt_r[d][W-1], cnt_r[d]};
            for (int k = 0; k < CORENUM; k++) begin
                sum_v = sum_v + (store[k] ? (core_result[k*DIM + d] ? P_ONE : N_ONE) : P_ZERO);
            end
            if (clr_s) begin
                cnt_s[d] = {W{1'b0}};
            end else if (sum_v > P_MAX) begin
                cnt_s[d] = P_MAX[W-1:0];
            end else if (sum_v < N_MAX) begin
                cnt_s[d] = N_MAX[W-1:0];
            end else begin
                cnt_s[d] = sum_v[W-1:0];
            end
        end
    end

    // Vote counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < DIM; d++) begin
                cnt_r[d] <= {W{1'b0}};
            end
        end else begin
            for (int d = 0; d < DIM; d++) begin
                cnt_r[d] <= cnt_s[d];
            end
        end
    end

    // Live majority sign from the registered counters
    always_comb begin
        sign_bit = {DIM{1'b0}};
        for (int d = 0; d < DIM; d++) begin
            if (cnt_r[d] == {W{1'b0}}) begin
                sign_bit[d] = TIE_VAL;
            end else begin
                sign_bit[d] = ~cnt_r[d][W-1];
            end
        end
    end

    // Readout FSM next-state and next-output logic
    always_comb begin
        state_s   = state_r;
        beat_s    = beat_r;
        snap_s    = snap_r;
        m_valid_s = m_valid_r;
        m_last_s  = m_last_r;
        done_s    = 1'b0;
        m_data_s  = {OUT_W{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s   = S_SEND;
                    beat_s    = {BW{1'b0}};
                    snap_s    = sign_bit;
                    m_valid_s = 1'b1;
                    m_last_s  = (LAST_BEAT == {BW{1'b0}});
                end else begin
                    state_s   = S_IDLE;
                    m_valid_s = 1'b0;
                    m_last_s  = 1'b0;
                end
            end
            S_SEND: begin
                if (m_valid_r && m_ready) begin
                    if (m_last_r) begin
                        state_s   = S_IDLE;
                        m_valid_s = 1'b0;
                        m_last_s  = 1'b0;
                        done_s    = 1'b1;
                    end else begin
                        beat_s    = beat_r + BEAT_ONE;
                        m_last_s  = (beat_s == LAST_BEAT);
                    end
                end else begin
                    state_s = S_SEND;
                end
            end
            default: begin
                state_s   = S_IDLE;
                m_valid_s = 1'b0;
                m_last_s  = 1'b0;
            end
        endcase
        // Beat b carries snapshot dimensions [b*OUT_W +: OUT_W].
        for (int b = 0; b < NBEATS; b++) begin
            m_data_s = (m_valid_s && (beat_s == BW'(b))) ? snap_s[b*OUT_W +: OUT_W] : m_data_s;
        end
    end

    // Readout FSM state and registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            beat_r    <= {BW{1'b0}};
            snap_r    <= {DIM{1'b0}};
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= {OUT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            beat_r    <= beat_s;
            snap_r    <= snap_s;
            m_valid_r <= m_valid_s;
            m_last_r  <= m_last_s;
            m_data_r  <= m_data_s;
            busy_r    <= (state_s == S_SEND);
            done_r    <= done_s;
        end
    end

    assign m_data  = m_data_r;
    assign m_valid = m_valid_r;
    assign m_last  = m_last_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_hv_accum_stream.sv
// Self-checking bench for hv_accum_stream (DIM=64, OUT_W=32, CORENUM=4, W=4).
// A second instance with TIE_VAL=1 shares the stimulus so tie handling is
// checked for both polarities. The reference keeps per-dimension integer
// vote counts and a queue of expected beats.
module tb_hv_accum_stream;

    localparam int D    = 64;
    localparam int OW   = 32;
    localparam int CN   = 4;
    localparam int WW   = 4;
    localparam int NB   = D / OW;
    localparam int MAXC = 7;

    logic            clk = 1'b0;
    logic            rst, clear, start, m_ready;
    logic [CN-1:0]   store;
    logic [CN*D-1:0] core_result;

    logic [OW-1:0]   m_data, m_data_t1;
    logic            m_valid, m_last, busy, done;
    logic            m_valid_t1, m_last_t1, busy_t1, done_t1;
    logic [D-1:0]    sign_bit, sign_bit_t1;

    // reference state
    int              cnt [D];
    logic [OW-1:0]   exp_q [$];
    bit              done_exp;
    int              checks   = 0;
    int              failures = 0;

    always #5 clk = ~clk;

    hv_accum_stream #(.DIM(D), .CORENUM(CN), .W(WW), .OUT_W(OW),
                      .TIE_VAL(1'b0), .CLR_ON_START(1'b1)) dut (
        .clk(clk), .rst(rst), .core_result(core_result), .store(store),
        .clear(clear), .start(start), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done),
        .sign_bit(sign_bit));

    hv_accum_stream #(.DIM(D), .CORENUM(CN), .W(WW), .OUT_W(OW),
                      .TIE_VAL(1'b1), .CLR_ON_START(1'b1)) dut_t1 (
        .clk(clk), .rst(rst), .core_result(core_result), .store(store),
        .clear(clear), .start(start), .m_data(m_data_t1), .m_valid(m_valid_t1),
        .m_ready(m_ready), .m_last(m_last_t1), .busy(busy_t1), .done(done_t1),
        .sign_bit(sign_bit_t1));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] model_sign(input logic tie);
        logic [D-1:0] r;
        for (int d = 0; d < D; d++) begin
            r[d] = (cnt[d] > 0) ? 1'b1 : ((cnt[d] < 0) ? 1'b0 : tie);
        end
        return r;
    endfunction

    function automatic logic [CN*D-1:0] pk(input logic [D-1:0] c0, input logic [D-1:0] c1,
                                           input logic [D-1:0] c2, input logic [D-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // One clock: check outputs against the reference, drive inputs, advance reference.
    task automatic cycle(input bit r, input bit c, input bit s, input bit rdy,
                         input logic [CN-1:0] st, input logic [CN*D-1:0] cr);
        logic [D-1:0]  sv;
        logic [OW-1:0] ed;
        bit            started;
        int            sum;
        @(negedge clk);
        ed = (exp_q.size() > 0) ? exp_q[0] : {OW{1'b0}};
        check_eq("m_valid", {63'd0, m_valid}, {63'd0, exp_q.size() > 0});
        check_eq("busy", {63'd0, busy}, {63'd0, exp_q.size() > 0});
        check_eq("m_last", {63'd0, m_last}, {63'd0, exp_q.size() == 1});
        check_eq("m_data", {32'd0, m_data}, {32'd0, ed});
        check_eq("done", {63'd0, done}, {63'd0, done_exp});
        check_eq("sign_bit", sign_bit, model_sign(1'b0));
        check_eq("sign_bit_tie1", sign_bit_t1, model_sign(1'b1));

        rst = r; clear = c; start = s; m_ready = rdy; store = st; core_result = cr;

        started = 1'b0;
        if (r) begin
            for (int d = 0; d < D; d++) cnt[d] = 0;
            exp_q.delete();
            done_exp = 1'b0;
        end else begin
            done_exp = 1'b0;
            if (exp_q.size() == 0) begin
                if (s) begin
                    sv = model_sign(1'b0);
                    for (int b = 0; b < NB; b++) exp_q.push_back(sv[b*OW +: OW]);
                    started = 1'b1;
                end
            end else if (rdy) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) done_exp = 1'b1;
            end
            for (int d = 0; d < D; d++) begin
                if (c || started) begin
                    cnt[d] = 0;
                end else begin
                    sum = cnt[d];
                    for (int k = 0; k < CN; k++) begin
                        if (st[k]) sum += cr[k*D + d] ? 1 : -1;
                    end
                    cnt[d] = (sum > MAXC) ? MAXC : ((sum < -MAXC) ? -MAXC : sum);
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy, 4'b0000, {CN*D{1'b0}});
    endtask

    function automatic logic [CN*D-1:0] rand_cores();
        logic [CN*D-1:0] v;
        for (int i = 0; i < (CN*D)/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    logic [D-1:0] ones, zeros, pat_a, pat_5;

    initial begin
        ones  = {D{1'b1}};
        zeros = {D{1'b0}};
        pat_a = {(D/2){2'b10}};
        pat_5 = {(D/2){2'b01}};
        for (int d = 0; d < D; d++) cnt[d] = 0;
        done_exp = 1'b0;
        rst = 1'b1; clear = 1'b0; start = 1'b0; m_ready = 1'b0;
        store = 4'b0000; core_result = {CN*D{1'b0}};

        // reset state
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, {CN*D{1'b0}});
        idle(1, 1'b0);

        // majority: two ones vs one zero, then stream both beats with ready high
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0111, pk(ones, ones, zeros, zeros));
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, {CN*D{1'b0}});
        idle(4, 1'b1);

        // tie: opposite patterns on two cores
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, pk(pat_a, pat_5, zeros, zeros));
        idle(2, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, {CN*D{1'b0}});

        // saturation at +7, then two all-zero rounds to -1
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, pk(ones, ones, ones, ones));
        for (int i = 0; i < 2; i++)  cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, pk(zeros, zeros, zeros, zeros));
        idle(2, 1'b1);

        // backpressure: ready 0,0,1,0,1 after start
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, rand_cores());
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, {CN*D{1'b0}});
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, {CN*D{1'b0}});
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, {CN*D{1'b0}});
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, {CN*D{1'b0}});
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, {CN*D{1'b0}});
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, {CN*D{1'b0}});
        idle(2, 1'b0);

        // clear and store together
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, pk(ones, ones, ones, ones));
        idle(2, 1'b1);

        // start with a simultaneous store
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, rand_cores());
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, pk(ones, ones, ones, ones));
        idle(4, 1'b1);

        // start held during SEND, with accumulation running alongside
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, rand_cores());
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, {CN*D{1'b0}});
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, rand_cores());
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, rand_cores());
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, {CN*D{1'b0}});
        idle(4, 1'b1);

        // reset while beat 0 is stalled
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, rand_cores());
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, {CN*D{1'b0}});
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, {CN*D{1'b0}});
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, {CN*D{1'b0}});
        idle(3, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                  CN'($urandom_range(0, 15)), rand_cores());
        end
        idle(4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hv_accum_stream.md
Name: hv_accum_stream

Overview:
Multi-core hypervector bundling accumulator with a full-width streaming readout.
- Each dimension has a saturating signed vote counter. Every storing core adds +1 for a 1 bit and -1 for a 0 bit.
- The majority sign vector is continuously available on sign_bit.
- On request, the sign vector is snapshotted and serialised as OUT_W-bit beats over a valid/ready stream toward the DMA/ACP write path.
- Sits between the core array and the output DMA. Replaces the fixed 8-core, 32-bit-only output controller.

Parameters:
DIM, 1024, hypervector dimension in bits; must be a multiple of OUT_W
CORENUM, 8, number of core result inputs (1..32)
W, 26, signed counter width; must be at least clog2(CORENUM) + 2
OUT_W, 512, stream beat width in bits
TIE_VAL, 0, sign bit emitted when a counter equals 0
CLR_ON_START, 1, when 1, counters are zeroed in the same cycle the snapshot is taken

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, synchronous, active-high
core_result  in  CORENUM*DIM  core k result vector at bits [k*DIM +: DIM], k = 0..CORENUM-1
store  in  CORENUM  per-core accumulate enable, bit k qualifies core k
clear  in  1  synchronous zeroing of all counters
start  in  1  snapshot sign vector and begin readout
m_data  out  OUT_W  stream beat
m_valid  out  1  beat valid
m_ready  in  1  downstream ready
m_last  out  1  final beat of the vector
busy  out  1  high while in SEND state
done  out  1  one-cycle pulse after the last beat is accepted
sign_bit  out  DIM  live majority vector

Behaviour:
- Reset values: all counters 0; FSM in IDLE; m_valid=0, m_last=0, busy=0, done=0, m_data=0, snapshot register 0.
  - sign_bit after reset is all TIE_VAL.
- Counter update, per dimension d, each cycle:
  - delta = sum over k with store[k]=1 of (core_result[k*DIM+d] ? +1 : -1); range -CORENUM..+CORENUM.
  - cnt <= sat(cnt + delta), clamped to [-(2^(W-1)-1), +(2^(W-1)-1)]. Saturation is symmetric; the most-negative code is never produced.
  - store = 0 leaves cnt unchanged.
- Clear priority: clear=1 forces cnt <= 0 and discards that cycle's stores. rst overrides everything.
- sign_bit[d] is combinational from the registered cnt: 1 if cnt>0, 0 if cnt<0, TIE_VAL if cnt==0.
  - A store in cycle t is reflected on sign_bit in cycle t+1.
- FSM states: IDLE, SEND.
  - IDLE: start=1 -> snapshot <= sign_bit (pre-update value of this cycle); beat <= 0; go to SEND.
    - If CLR_ON_START=1, counters go to 0 in that cycle: start acts as clear, discards stores, and has priority over stores.
  - SEND: m_valid=1, busy=1, m_data = snapshot[beat*OUT_W +: OUT_W], m_last = (beat == DIM/OUT_W - 1).
    - On m_valid & m_ready: if m_last, go to IDLE and pulse done in the next cycle; otherwise beat <= beat+1.
- Latency: start in cycle t -> m_valid=1 with beat 0 in cycle t+1. With m_ready held high, DIM/OUT_W consecutive beats, then done.
- Stall: while m_valid & !m_ready, m_data and m_last hold stable. m_valid never drops before acceptance.
- start during SEND is ignored; no queueing.
- Accumulation (store/clear) continues during SEND and does not disturb the snapshot.
- rst mid-SEND: next cycle m_valid=0, IDLE, counters 0, no done pulse.
- DIM == OUT_W: a single beat with m_last=1.
- Beat order is low dimensions first. Bit d of the vector is bit (d mod OUT_W) of beat floor(d/OUT_W).

Test Plan:
- Bench config DIM=64, OUT_W=32, CORENUM=4, W=4, TIE_VAL=0, CLR_ON_START=1.
- Majority: cycle1 store=4'b0111 with cores 0,1 = all-ones and core 2 = all-zeros; start in cycle 2 -> cnt=+1 everywhere; beats 0xFFFFFFFF then 0xFFFFFFFF with m_last on beat 1; done pulses one cycle after beat 1 is accepted.
- Tie: cores 0,1 drive opposite patterns (0xAAAA... vs 0x5555...), store=4'b0011 -> sign_bit all 0 (TIE_VAL). Rebuild with TIE_VAL=1 -> all 1.
- Saturation: 10 cycles, store=4'b1111, all-ones -> cnt clamps at +7, never wraps. Then 2 cycles of all-zeros with 4 cores -> cnt=-1, sign_bit all 0.
- Backpressure: m_ready pattern 0,0,1,0,1 after start -> m_data/m_last stable across stalls; exactly 2 beats transferred; busy falls after the second acceptance.
- Collisions:
  - clear and store in the same cycle -> cnt stays 0.
  - start in the same cycle as store=4'b1111 (all-ones) -> snapshot excludes that store; counters are 0 afterwards.
  - start asserted during SEND -> no effect on the beat sequence.
- rst asserted while beat 0 is stalled -> m_valid=0 next cycle, no done pulse, sign_bit = all TIE_VAL.
